div3_word_serializer: RTL

//   Parallel-to-serial stage that feeds the divide-by-3 detector FSM. Accepts WIDTH-bit

---
 rtl/div3_pkg.sv | 11 +
 rtl/div3_skid_buf.sv | 29 ++
 rtl/div3_word_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// Shared types and defaults for the divide-by-3 word serializer and its helpers.
package div3_pkg;

  localparam int DIV3_WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

endpackage

// File: rtl/div3_skid_buf.sv
// One-entry holding buffer used by div3_word_serializer when DIV3_SER_SKID_EN is defined.
module div3_skid_buf
  import div3_pkg::*;
#(
  parameter int WIDTH = DIV3_WORD_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // NOTE: the data register is reset as well, so a stale word can never resurface after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
      full <= 1'b0;
    end else if (push) begin
      data <= push_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/div3_word_serializer.sv
// MSB-first word serializer with sof/eof framing for the divide-by-3 detector.
// Define DIV3_SER_SKID_EN for a one-entry skid buffer giving zero-gap back-to-back words.
module div3_word_serializer
  import div3_pkg::*;
#(
  parameter int WIDTH = DIV3_WORD_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic             ser_eof,
  output logic             busy
);

  localparam int              CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, load_data;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept, word_done, load_word;

  assign accept    = in_valid && in_ready;
  assign word_done = (state == SHIFT) && (bit_cnt == '0);

`ifdef DIV3_SER_SKID_EN
  logic             buf_full, buf_push, buf_pop;
  logic [WIDTH-1:0] buf_data;

  // A word accepted on the eof cycle bypasses the buffer and goes straight into shreg.
  assign buf_push  = accept && (state == SHIFT) && !word_done;
  assign buf_pop   = word_done && buf_full;
  assign load_word = ((state == IDLE) && accept) || (word_done && (buf_full || accept));
  assign load_data = buf_full ? buf_data : in_data;

  div3_skid_buf #(.WIDTH(WIDTH)) u_skid_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (buf_push),
    .push_data (in_data),
    .pop       (buf_pop),
    .data      (buf_data),
    .full      (buf_full)
  );
`else
  assign load_word = accept;
  assign load_data = in_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_word) state_next = SHIFT;
      SHIFT:   if (word_done && !load_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_sof   = 1'b0;
    ser_eof   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = shreg[WIDTH-1];
        ser_sof   = (bit_cnt == CNT_TOP);
        ser_eof   = (bit_cnt == '0);
        busy      = 1'b1;
      end
      default: ;
    endcase
`ifdef DIV3_SER_SKID_EN
    in_ready = !buf_full;
    busy     = busy || buf_full;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load_word) begin
      shreg   <= load_data;
      bit_cnt <= CNT_TOP;
    end else if (state == SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

endmodule
